pp3_ffbank_rst_seq: RTL and testbench
=====================================

Name: pp3_ffbank_rst_seq

Overview:
- Synchronous controller that sequences the async clear/preset and enable pins of up to NBANKS banks of PP3 dffepc flops.
- Holds every bank in its init state, then releases banks one at a time with a fixed stagger. This avoids a simultaneous async-release across the fabric.
- Gates per-bank clock enables until all banks are live, and services runtime re-init requests through a REQ/ACK handshake.
- Sits between system reset logic and dffepc-based register banks; this block's own flops are purely synchronous.

Parameters:
- NBANKS, 4, number of flop banks controlled (1..16).
- HOLD_CYCLES, 4, cycles all banks are held in clear/preset after reset or re-init (>=1).
- STAGGER, 2, cycles between successive bank releases (>=1).
- INIT_MASK, {NBANKS{1'b0}}, per-bank init value: bit=0 drives CLR, bit=1 drives PRE.

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- RST  in  1  synchronous active-high reset.
- REINIT_REQ  in  1  level request to re-initialise all banks; held until ACK.
- EN_REQ  in  NBANKS  per-bank enable from user logic.
- CLR  out  NBANKS  to dffepc CLR pins, active-high.
- PRE  out  NBANKS  to dffepc PRE pins, active-high.
- EN  out  NBANKS  to dffepc EN pins.
- READY  out  1  all banks released and enables live.
- REINIT_ACK  out  1  one-cycle pulse when a re-init request is accepted.

Behaviour:
- All outputs are registered.
- States: HOLD, RELEASE, RUN. One shared timer; bank index BIDX.
- While RST=1:
  - state=HOLD, timer=0, BIDX=0.
  - CLR=~INIT_MASK, PRE=INIT_MASK, EN=0, READY=0, REINIT_ACK=0.
- HOLD:
  - Timer counts cycles after RST falls.
  - Banks stay asserted for exactly HOLD_CYCLES cycles, then go to RELEASE with BIDX=0.
- RELEASE:
  - Bank BIDX's CLR/PRE bit is deasserted. Deassertion edges follow the release schedule below.
  - BIDX increments every STAGGER cycles.
  - After the last bank is released, wait STAGGER cycles, then go to RUN.
- Release schedule, counting cycle 0 as the first cycle after RST low:
  - bank k deasserts at cycle HOLD_CYCLES + k*STAGGER.
  - READY rises at cycle HOLD_CYCLES + NBANKS*STAGGER. Defaults: banks at 4, 6, 8, 10; READY at 12.
- EN:
  - EN=0 in HOLD and RELEASE.
  - In RUN, EN=EN_REQ with one cycle of registration latency.
- CLR and PRE are never both asserted on the same bank.
- RUN with REINIT_REQ=1:
  - REINIT_ACK pulses for 1 cycle; next state HOLD.
  - In the same edge: READY=0, EN=0, all CLR/PRE reasserted, timer restarted.
  - Timing from ACK then matches the post-reset schedule.
- REINIT_REQ in HOLD/RELEASE: not acknowledged. It is serviced on the first RUN cycle if still held, which gives one re-init, not two.
- REINIT_REQ still high in the cycle after ACK is treated as a new request only once RUN is reached again. Requesters must drop REQ after ACK.
- RST mid-RELEASE or mid-RUN: immediate return to reset values on that edge. RST overrides REINIT_REQ.
- Timer width: $clog2(max(HOLD_CYCLES,STAGGER)+1). BIDX width: $clog2(NBANKS+1).
- NBANKS=1: a single release, then READY after STAGGER cycles.
- Elaboration error if HOLD_CYCLES<1, STAGGER<1, or NBANKS is outside 1..16.

Optional Feature:
- Macro: PP3_FFBANK_RST_SEQ_STATUS_EN.
- Defined:
  - Adds output STATUS[1:0]: HOLD=0, RELEASE=1, RUN=2; reset value 0.
  - Adds output REINIT_CNT[7:0]: increments on each REINIT_ACK and saturates at 255; cleared by RST.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Decomposition:
- Package pp3_ffbank_rst_seq_pkg contains:
  - state enum (ST_HOLD=2'd0, ST_RELEASE=2'd1, ST_RUN=2'd2);
  - a clog2-max helper function for the timer width;
  - the NBANKS upper-limit constant (16).
- One sub-module, pp3_rstseq_timer: loadable up-counter with terminal-count flag, synchronous clear, parameterised width.

Test Plan:
- Defaults, RST high 3 cycles then low -> CLR=4'b1111 for cycles 0..3; CLR bits clear at cycles 4, 6, 8, 10; READY=1 at cycle 12; EN=0 throughout.
- INIT_MASK=4'b1010 with reset sequence -> PRE=4'b1010, CLR=4'b0101 after reset; never both set on a bank; bits release in index order on the same schedule.
- In RUN, EN_REQ=4'b0110 -> EN=4'b0110 one cycle later. Then REINIT_REQ=1 for 3 cycles -> single-cycle ACK, EN=0 and all bits reasserted next edge, READY again 12 cycles after ACK, no second ACK.
- RST pulsed 1 cycle at cycle 7 (mid-RELEASE, banks 0-1 released) -> all CLR reasserted on that edge; full schedule restarts from RST low.
- REINIT_REQ raised at cycle 2 and held -> no ACK until cycle 12 (first RUN cycle); ACK at cycle 12; second READY at cycle 24.
- With PP3_FFBANK_RST_SEQ_STATUS_EN, 300 re-init cycles -> STATUS walks 0→1→2 per cycle; REINIT_CNT saturates at 255.

Source files
------------

// File: rtl/pp3_ffbank_rst_seq_pkg.sv
// Shared types and constants for the dffepc bank reset sequencer.
package pp3_ffbank_rst_seq_pkg;

  localparam int unsigned NBANKS_MAX = 16;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Width needed to count up to max(a,b).
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/pp3_rstseq_timer.sv
// Loadable up-counter with terminal-count flag and synchronous clear.
module pp3_rstseq_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] tc_val,
  output logic         tc_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (load) cnt_d = load_val;
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_c = (cnt_q == tc_val);

endmodule

// File: rtl/pp3_ffbank_rst_seq.sv
// Staggered CLR/PRE release and enable gating for dffepc flop banks.
// Optional STATUS / REINIT_CNT outputs under PP3_FFBANK_RST_SEQ_STATUS_EN.
module pp3_ffbank_rst_seq
  import pp3_ffbank_rst_seq_pkg::*;
#(
  parameter int unsigned         NBANKS      = 4,
  parameter int unsigned         HOLD_CYCLES = 4,
  parameter int unsigned         STAGGER     = 2,
  parameter logic [NBANKS-1:0]   INIT_MASK   = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REINIT_REQ,
  input  logic [NBANKS-1:0] EN_REQ,
  output logic [NBANKS-1:0] CLR,
  output logic [NBANKS-1:0] PRE,
  output logic [NBANKS-1:0] EN,
  output logic              READY,
  output logic              REINIT_ACK
`ifdef PP3_FFBANK_RST_SEQ_STATUS_EN
  ,
  output logic [1:0]        STATUS,
  output logic [7:0]        REINIT_CNT
`endif
);

  localparam int unsigned TW = timer_width(HOLD_CYCLES, STAGGER);
  localparam int unsigned BW = $clog2(NBANKS + 1);

  if (NBANKS == 0 || NBANKS > NBANKS_MAX || HOLD_CYCLES == 0 || STAGGER == 0) begin : g_bad_param
    $error("pp3_ffbank_rst_seq: illegal NBANKS/HOLD_CYCLES/STAGGER");
  end

  state_e            state_q, state_d;
  logic [BW-1:0]     bidx_q, bidx_d;
  logic [NBANKS-1:0] clr_q, clr_d, pre_q, pre_d, en_q, en_d;
  logic              ready_q, ready_d, ack_q, ack_d;
  logic              tmr_load_c, tmr_tc_c;
  logic [TW-1:0]     tmr_tc_val_c;

  assign tmr_tc_val_c = (state_q == ST_HOLD) ? TW'(HOLD_CYCLES - 1) : TW'(STAGGER - 1);

  pp3_rstseq_timer #(.W(TW)) u_timer (
    .clk      (CLK),
    .clr      (RST),
    .load     (tmr_load_c),
    .load_val ('0),
    .tc_val   (tmr_tc_val_c),
    .tc_c     (tmr_tc_c)
  );

  always_comb begin
    state_d    = state_q;
    bidx_d     = bidx_q;
    clr_d      = clr_q;
    pre_d      = pre_q;
    en_d       = '0;
    ready_d    = ready_q;
    ack_d      = 1'b0;
    tmr_load_c = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (tmr_tc_c) begin
          state_d    = ST_RELEASE;
          bidx_d     = '0;
          clr_d[0]   = 1'b0;
          pre_d[0]   = 1'b0;
          tmr_load_c = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (tmr_tc_c) begin
          tmr_load_c = 1'b1;
          if (bidx_q == BW'(NBANKS - 1)) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            bidx_d = bidx_q + BW'(1);
            for (int i = 0; i < int'(NBANKS); i++) begin
              if (BW'(i) == bidx_d) begin
                clr_d[i] = 1'b0;
                pre_d[i] = 1'b0;
              end
            end
          end
        end
      end
      ST_RUN: en_d = EN_REQ;
      default: state_d = ST_HOLD;
    endcase
    // A request pending as RUN is reached (or during RUN) restarts the whole sequence.
    if (REINIT_REQ && (state_d == ST_RUN)) begin
      state_d    = ST_HOLD;
      bidx_d     = '0;
      clr_d      = ~INIT_MASK;
      pre_d      = INIT_MASK;
      en_d       = '0;
      ready_d    = 1'b0;
      ack_d      = 1'b1;
      tmr_load_c = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_HOLD;
      bidx_q  <= '0;
      clr_q   <= ~INIT_MASK;
      pre_q   <= INIT_MASK;
      en_q    <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      clr_q   <= clr_d;
      pre_q   <= pre_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  assign CLR        = clr_q;
  assign PRE        = pre_q;
  assign EN         = en_q;
  assign READY      = ready_q;
  assign REINIT_ACK = ack_q;

`ifdef PP3_FFBANK_RST_SEQ_STATUS_EN
  logic [7:0] reinit_cnt_q, reinit_cnt_d;

  always_comb begin
    reinit_cnt_d = reinit_cnt_q;
    if (ack_d && (reinit_cnt_q != 8'hFF)) reinit_cnt_d = reinit_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) reinit_cnt_q <= '0;
    else     reinit_cnt_q <= reinit_cnt_d;
  end

  assign STATUS     = state_q;
  assign REINIT_CNT = reinit_cnt_q;
`endif

endmodule

// File: tb/tb_pp3_ffbank_rst_seq.sv
// Directed bench for pp3_ffbank_rst_seq (default and INIT_MASK=4'b1010 instances).
module tb_pp3_ffbank_rst_seq;

  logic       clk = 1'b0;
  logic       rst, req;
  logic [3:0] en_req;
  logic [3:0] clr0, pre0, en0, clr1, pre1, en1;
  logic       rdy0, ack0, rdy1, ack1;
`ifdef PP3_FFBANK_RST_SEQ_STATUS_EN
  logic [1:0] st0, st1;
  logic [7:0] rc0, rc1;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pp3_ffbank_rst_seq u0 (
    .CLK(clk), .RST(rst), .REINIT_REQ(req), .EN_REQ(en_req),
    .CLR(clr0), .PRE(pre0), .EN(en0), .READY(rdy0), .REINIT_ACK(ack0)
`ifdef PP3_FFBANK_RST_SEQ_STATUS_EN
    , .STATUS(st0), .REINIT_CNT(rc0)
`endif
  );

  pp3_ffbank_rst_seq #(.INIT_MASK(4'b1010)) u1 (
    .CLK(clk), .RST(rst), .REINIT_REQ(req), .EN_REQ(en_req),
    .CLR(clr1), .PRE(pre1), .EN(en1), .READY(rdy1), .REINIT_ACK(ack1)
`ifdef PP3_FFBANK_RST_SEQ_STATUS_EN
    , .STATUS(st1), .REINIT_CNT(rc1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expects to be entered in cycle 0 (first cycle with RST low); leaves in cycle 13.
  task automatic sched(input string tag);
    logic [3:0] held;
    for (int c = 0; c < 14; c++) begin
      for (int k = 0; k < 4; k++) held[k] = (c < 4 + 2 * k);
      chk($sformatf("%s_clr0_c%0d", tag, c), 32'(clr0), 32'(held));
      chk($sformatf("%s_pre0_c%0d", tag, c), 32'(pre0), 32'h0);
      chk($sformatf("%s_clr1_c%0d", tag, c), 32'(clr1), 32'(held & 4'b0101));
      chk($sformatf("%s_pre1_c%0d", tag, c), 32'(pre1), 32'(held & 4'b1010));
      chk($sformatf("%s_both1_c%0d", tag, c), 32'(clr1 & pre1), 32'h0);
      chk($sformatf("%s_rdy0_c%0d", tag, c), 32'(rdy0), 32'(c >= 12));
      chk($sformatf("%s_rdy1_c%0d", tag, c), 32'(rdy1), 32'(c >= 12));
      chk($sformatf("%s_en0_c%0d", tag, c), 32'(en0), 32'h0);
      chk($sformatf("%s_ack0_c%0d", tag, c), 32'(ack0), 32'h0);
`ifdef PP3_FFBANK_RST_SEQ_STATUS_EN
      chk($sformatf("%s_status_c%0d", tag, c), 32'(st0), (c < 4) ? 32'd0 : (c < 12) ? 32'd1 : 32'd2);
`endif
      if (c < 13) tick();
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; en_req = 4'h0;
    tick(); tick(); tick();
    chk("rst_clr0", 32'(clr0), 32'hF);
    chk("rst_pre0", 32'(pre0), 32'h0);
    chk("rst_clr1", 32'(clr1), 32'h5);
    chk("rst_pre1", 32'(pre1), 32'hA);
    chk("rst_en0", 32'(en0), 32'h0);
    chk("rst_rdy0", 32'(rdy0), 32'h0);
    chk("rst_ack0", 32'(ack0), 32'h0);

    // Power-up schedule, then enables in RUN.
    rst = 1'b0;
    sched("pwr");
    en_req = 4'b0110;
    tick();
    chk("run_en0", 32'(en0), 32'h6);
    chk("run_en1", 32'(en1), 32'h6);

    // Three-cycle re-init request: one ACK, full restart from the ACK cycle.
    req = 1'b1;
    tick();
    chk("ri_ack0", 32'(ack0), 32'h1);
    chk("ri_ack1", 32'(ack1), 32'h1);
    chk("ri_en0", 32'(en0), 32'h0);
    chk("ri_clr0", 32'(clr0), 32'hF);
    chk("ri_pre1", 32'(pre1), 32'hA);
    chk("ri_rdy0", 32'(rdy0), 32'h0);
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 2) req = 1'b0;
      chk($sformatf("ri_ack_c%0d", c), 32'(ack0), 32'h0);
      chk($sformatf("ri_rdy_c%0d", c), 32'(rdy0), 32'(c >= 12));
      chk($sformatf("ri_en_c%0d", c), 32'(en0), (c == 13) ? 32'h6 : 32'h0);
    end
    en_req = 4'h0;

    // One-cycle RST mid-release restarts everything.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    chk("mid_clr0_c7", 32'(clr0), 32'hC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_clr0", 32'(clr0), 32'hF);
    chk("mid_rst_pre1", 32'(pre1), 32'hA);
    sched("rst2");

    // Request raised during HOLD is deferred until RUN would be reached.
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    req = 1'b1;
    for (int c = 2; c < 12; c++) begin
      chk($sformatf("early_ack_c%0d", c), 32'(ack0), 32'h0);
      tick();
    end
    chk("early_ack_c12", 32'(ack0), 32'h1);
    chk("early_rdy_c12", 32'(rdy0), 32'h0);
    chk("early_clr_c12", 32'(clr0), 32'hF);
    tick();
    req = 1'b0;
    for (int c = 13; c <= 24; c++) begin
      chk($sformatf("early2_ack_c%0d", c), 32'(ack0), 32'h0);
      chk($sformatf("early2_rdy_c%0d", c), 32'(rdy0), 32'(c >= 24));
      if (c < 24) tick();
    end

`ifdef PP3_FFBANK_RST_SEQ_STATUS_EN
    // 300 handshaked re-inits: counter saturates.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("st_rst_cnt", 32'(rc0), 32'h0);
    for (int i = 0; i < 300; i++) begin
      int n;
      n = 0;
      while (!rdy0 && n < 30) begin tick(); n++; end
      chk("st_wait_ready", 32'(rdy0), 32'h1);
      chk("st_status_run", 32'(st0), 32'd2);
      req = 1'b1;
      n = 0;
      tick();
      while (!ack0 && n < 30) begin tick(); n++; end
      req = 1'b0;
      chk("st_wait_ack", 32'(ack0), 32'h1);
      chk("st_status_hold", 32'(st0), 32'd0);
      if (i == 0) chk("st_cnt1", 32'(rc0), 32'h1);
    end
    chk("st_cnt_sat", 32'(rc0), 32'hFF);
    chk("st_cnt_sat1", 32'(rc1), 32'hFF);
`else
    chk("nostatus_rdy", 32'(rdy0), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
